// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter for the 0000/1111 recognizer: shifts a loaded pattern out LSB first,
// once or repeated, and produces z_exp as a reference for the recognizer's match output.
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             start,
  input  logic             rpt,
  input  logic             stop,
  output logic             w,
  output logic             valid,
  output logic             done,
  output logic             z_exp
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [LW-1:0]    r_len;
  logic [IW-1:0]    r_idx;
  logic [2:0]       r_run;
  logic             r_last_bit;

  logic [LW-1:0]    w_len_clamp;
  logic [LW-1:0]    w_start_len;
  logic             w_valid;
  logic             w_bit;
  logic             w_is_last;

  always_comb begin
    w_len_clamp = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
    w_start_len = load ? w_len_clamp : r_len;
    w_valid     = (r_state == SHIFT);
    w_bit       = r_pat[r_idx];
    w_is_last   = (LW'(r_idx) == r_len - LW'(1));
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  assign valid = w_valid;
  assign w     = w_valid & w_bit;
  assign done  = w_valid & w_is_last;
  assign z_exp = w_valid & (w_bit == r_last_bit) & (r_run >= 3'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pat      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_run      <= '0;
      r_last_bit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_pat <= pattern;
            r_len <= w_len_clamp;
          end
          // A zero length only exists after reset with no load; nothing to send then.
          if (start && w_start_len != '0) begin
            r_state <= SHIFT;
            r_idx   <= '0;
          end
        end
        SHIFT: begin
          r_last_bit <= w_bit;
          if (w_bit == r_last_bit && r_run != '0)
            r_run <= (r_run == 3'd4) ? 3'd4 : r_run + 3'd1;
          else
            r_run <= 3'd1;
          if (stop) begin
            r_state <= IDLE;
            r_run   <= '0;
          end else if (w_is_last) begin
            if (rpt) begin
              r_idx <= '0;
            end else begin
              r_state <= IDLE;
              r_run   <= '0;
            end
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: expected {w,valid,done,z_exp} per cycle is queued
// when stimulus is driven and compared at the following negedge.
module tb_serial_pattern_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        load, start, rpt, stop;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        w, valid, done, z_exp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        ld, st, rp, sp;
    logic [15:0] pat;
    logic [4:0]  ln;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs[11];

  serial_pattern_gen #(.WIDTH(16), .LW(5)) dut (
    .clock(clock), .reset(reset), .load(load), .pattern(pattern), .len(len),
    .start(start), .rpt(rpt), .stop(stop),
    .w(w), .valid(valid), .done(done), .z_exp(z_exp)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {w,valid,done,z}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, queue expectation, let one posedge pass, compare.
  task automatic step(input string nm, input logic ld, input logic st, input logic rp,
                      input logic sp, input logic [15:0] pat, input logic [4:0] ln,
                      input logic [3:0] exp);
    sb_t e;
    load = ld; start = st; rpt = rp; stop = sp; pattern = pat; len = ln;
    e.name = nm; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = sb_q.pop_front();
    check(e.name, {w, valid, done, z_exp}, e.exp);
  endtask

  initial begin
    reset = 1'b1; load = 0; start = 0; rpt = 0; stop = 0; pattern = '0; len = '0;
    @(negedge clock);
    check("reset_state", {w, valid, done, z_exp}, 4'b0000);
    @(negedge clock);
    reset = 1'b0;

    // 000F, len 8, single pass: load, start, 8 bits, then idle
    vecs[0]  = '{1, 0, 0, 0, 16'h000F, 5'd8, 4'b0000};
    vecs[1]  = '{0, 1, 0, 0, 16'h0000, 5'd0, 4'b1100};
    vecs[2]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b1100};
    vecs[3]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b1100};
    vecs[4]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b1101};
    vecs[5]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0100};
    vecs[6]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0100};
    vecs[7]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0100};
    vecs[8]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0111};
    vecs[9]  = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0000};
    vecs[10] = '{0, 0, 0, 0, 16'h0000, 5'd0, 4'b0000};
    for (int i = 0; i < 11; i++)
      step($sformatf("vec000F_%0d", i), vecs[i].ld, vecs[i].st, vecs[i].rp, vecs[i].sp,
           vecs[i].pat, vecs[i].ln, vecs[i].exp);

    // AAAA, len 0 (=16), repeat: alternating bits, done every 16th cycle, no gap
    for (int k = 0; k < 34; k++) begin
      logic [3:0] e;
      e = {logic'(k % 2), 1'b1, logic'(k % 16 == 15), 1'b0};
      step($sformatf("aaaa_rpt_%0d", k), k == 0, k == 0, 1'b1, 1'b0, 16'hAAAA, 5'd0, e);
    end
    step("aaaa_stop", 0, 0, 1, 1, 16'h0, 5'd0, 4'b0000);

    // 0003, len 3, repeat, loaded together with start
    for (int k = 0; k < 9; k++) begin
      logic [3:0] e;
      e = {logic'(k % 3 != 2), 1'b1, logic'(k % 3 == 2), 1'b0};
      step($sformatf("p3_rpt_%0d", k), k == 0, k == 0, 1'b1, 1'b0, 16'h0003, 5'd3, e);
    end
    step("p3_stop", 0, 0, 1, 1, 16'h0, 5'd0, 4'b0000);

    // len 1 repeat: constant 1, done every cycle, z_exp from the 4th bit
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      e = {1'b1, 1'b1, 1'b1, logic'(k >= 3)};
      step($sformatf("len1_rpt_%0d", k), k == 0, k == 0, 1'b1, 1'b0, 16'h0001, 5'd1, e);
    end
    step("len1_rpt_off", 0, 0, 0, 0, 16'h0, 5'd0, 4'b0000);

    // stop during bit 2 clears run history
    step("stop_load", 1, 0, 0, 0, 16'h00FF, 5'd8, 4'b0000);
    step("stop_b0", 0, 1, 0, 0, 16'h0, 5'd0, 4'b1100);
    step("stop_b1", 0, 0, 0, 0, 16'h0, 5'd0, 4'b1100);
    step("stop_b2", 0, 0, 0, 0, 16'h0, 5'd0, 4'b1100);
    step("stop_abort", 0, 0, 0, 1, 16'h0, 5'd0, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      e = {1'b1, 1'b1, logic'(k == 7), logic'(k >= 3)};
      step($sformatf("restart_%0d", k), 0, k == 0, 0, 0, 16'h0, 5'd0, e);
    end
    step("restart_end", 0, 0, 0, 0, 16'h0, 5'd0, 4'b0000);

    // load/start during SHIFT are ignored
    step("shift_ld_b0", 0, 1, 0, 0, 16'h0, 5'd0, 4'b1100);
    step("shift_ld_b1", 1, 1, 0, 0, 16'h0000, 5'd4, 4'b1100);
    for (int k = 2; k < 8; k++) begin
      logic [3:0] e;
      e = {1'b1, 1'b1, logic'(k == 7), logic'(k >= 3)};
      step($sformatf("shift_ld_b%0d", k), 0, 0, 0, 0, 16'h0, 5'd0, e);
    end
    step("shift_ld_end", 0, 0, 0, 0, 16'h0, 5'd0, 4'b0000);
    step("idle_stop_ignored", 0, 1, 0, 1, 16'h0, 5'd0, 4'b1100);
    step("stop_at_b0", 0, 0, 0, 1, 16'h0, 5'd0, 4'b0000);

    // asynchronous reset mid-pass, then start without load sends nothing
    step("ar_b0", 0, 1, 0, 0, 16'h0, 5'd0, 4'b1100);
    step("ar_b1", 0, 0, 0, 0, 16'h0, 5'd0, 4'b1100);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {w, valid, done, z_exp}, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++)
      step($sformatf("noload_start_%0d", k), 0, 1, 0, 0, 16'h0, 5'd0, 4'b0000);
    step("reload_b0", 1, 1, 0, 0, 16'h000F, 5'd4, 4'b1100);
    step("reload_stop", 0, 0, 0, 1, 16'h0, 5'd0, 4'b0000);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
